red_pitaya_fads_sort_scheduler: RTL and testbench

//  Sits directly downstream of the FADS droplet classifier. Turns each sort decision

---
 rtl/red_pitaya_fads_sort_scheduler_pkg.sv | 17 +
 rtl/fads_event_fifo.sv | 60 ++++++
 rtl/red_pitaya_fads_sort_scheduler.sv | 166 ++++++++++++++++
 tb/tb_red_pitaya_fads_sort_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_fads_sort_scheduler_pkg.sv
// rtl/red_pitaya_fads_sort_scheduler_pkg.sv - shared FADS sort scheduler types and defaults
// Purpose: FSM state encoding and default widths shared by the sort scheduler
//          and the FADS classifier.
// Ports:   none (package)
package red_pitaya_fads_sort_scheduler_pkg;

   localparam int FADS_TW  = 32;   // timestamp / delay / width counter bits
   localparam int FADS_QAW = 3;    // log2 of pending-event queue depth
   localparam int FADS_CW  = 32;   // status counter bits

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } sort_state_t;

endpackage

// File: rtl/fads_event_fifo.sv
// rtl/fads_event_fifo.sv - show-ahead FIFO of pending sort deadlines
// Purpose: holds due timestamps of sort events in arrival order.
// Ports:   clk, rst (async active-high), push/push_data, pop, flush,
//          head (show-ahead data), full, empty, count (occupancy).
module fads_event_fifo #(
   parameter int W  = 32,
   parameter int AW = 3
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = count[AW];
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // a full queue still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/red_pitaya_fads_sort_scheduler.sv
// rtl/red_pitaya_fads_sort_scheduler.sv - delayed sort pulse scheduler for FADS
// Purpose: turns classifier sort decisions into sort pulses that fire a
//          programmable delay later, with a FIFO of pending deadlines.
// Ports:   adc_clk_i/adc_rst_i clock and async reset; sort_trig_i, enable_i,
//          flush_i control; sort_delay_i/pulse_width_i/pulse_gap_i timing;
//          sort_pulse_o, asg_trig_o outputs; pending_o occupancy;
//          fired/late/dropped saturating status counters.
module red_pitaya_fads_sort_scheduler
   import red_pitaya_fads_sort_scheduler_pkg::*;
#(
   parameter int            TW      = FADS_TW,
   parameter int            QAW     = FADS_QAW,
   parameter int            CW      = FADS_CW,
   parameter logic [TW-1:0] NOW_RST = '0      // timestamp value after reset
)(
   input  logic          adc_clk_i,
   input  logic          adc_rst_i,
   input  logic          sort_trig_i,
   input  logic          enable_i,
   input  logic          flush_i,
   input  logic [TW-1:0] sort_delay_i,
   input  logic [TW-1:0] pulse_width_i,
   input  logic [TW-1:0] pulse_gap_i,
   output logic          sort_pulse_o,
   output logic          asg_trig_o,
   output logic [QAW:0]  pending_o,
   output logic [CW-1:0] fired_cnt_o,
   output logic [CW-1:0] late_cnt_o,
   output logic [CW-1:0] dropped_cnt_o
);

   // delays beyond half the timestamp range would break the wrap-safe compare
   localparam logic [TW-1:0] D_MAX = {1'b0, {(TW-1){1'b1}}};
   localparam logic [TW-1:0] ONE   = TW'(1);

   sort_state_t   state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic          asg_q;
   logic          trig_q;
   logic [TW-1:0] now;
   logic [TW-1:0] d_eff, w_eff, due, head, el;
   logic          fifo_full, fifo_empty;
   logic          trig_event, ready, launch;

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         trig_q <= 1'b0;
         now    <= NOW_RST;
      end else begin
         trig_q <= sort_trig_i;
         now    <= now + ONE;
      end
   end

   assign trig_event = sort_trig_i & ~trig_q & enable_i & ~flush_i;

   always_comb begin
      d_eff = sort_delay_i;
      if (sort_delay_i == '0)       d_eff = ONE;
      else if (sort_delay_i > D_MAX) d_eff = D_MAX;
   end

   assign w_eff = (pulse_width_i == '0) ? ONE : pulse_width_i;
   assign due   = now + d_eff;
   // elapsed time since the head deadline; negative (MSB set) means not yet due
   assign el    = now - head;
   assign ready = ~fifo_empty & ~el[TW-1];
   // the end of a gap doubles as an idle cycle so the gap is exactly G clocks
   assign launch = ~flush_i & ready &
                   ((state == ST_IDLE) | ((state == ST_GAP) & (timer == '0)));

   fads_event_fifo #(.W(TW), .AW(QAW)) u_fifo (
      .clk       (adc_clk_i),
      .rst       (adc_rst_i),
      .push      (trig_event),
      .push_data (due),
      .pop       (launch),
      .flush     (flush_i),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (pending_o)
   );

   // state register
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         state <= ST_IDLE;
         timer <= '0;
         asg_q <= 1'b0;
      end else begin
         state <= state_next;
         timer <= timer_next;
         asg_q <= launch;
      end
   end

   // next-state logic; timer holds remaining cycles minus one
   always_comb begin
      state_next = state;
      timer_next = timer;
      if (flush_i) begin
         state_next = ST_IDLE;
         timer_next = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  state_next = ST_PULSE;
                  timer_next = w_eff - ONE;
               end
            end
            ST_PULSE: begin
               if (timer == '0) begin
                  if (pulse_gap_i != '0) begin
                     state_next = ST_GAP;
                     timer_next = pulse_gap_i - ONE;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  timer_next = timer - ONE;
               end
            end
            ST_GAP: begin
               if (timer == '0) begin
                  if (launch) begin
                     state_next = ST_PULSE;
                     timer_next = w_eff - ONE;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  timer_next = timer - ONE;
               end
            end
            default: begin
               state_next = ST_IDLE;
               timer_next = '0;
            end
         endcase
      end
   end

   // outputs
   always_comb begin
      sort_pulse_o = (state == ST_PULSE);
      asg_trig_o   = asg_q;
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         fired_cnt_o   <= '0;
         late_cnt_o    <= '0;
         dropped_cnt_o <= '0;
      end else begin
         if (launch && fired_cnt_o != '1)
            fired_cnt_o <= fired_cnt_o + CW'(1);
         if (launch && el != '0 && late_cnt_o != '1)
            late_cnt_o <= late_cnt_o + CW'(1);
         if (trig_event && fifo_full && !launch && dropped_cnt_o != '1)
            dropped_cnt_o <= dropped_cnt_o + CW'(1);
      end
   end

endmodule

// File: tb/tb_red_pitaya_fads_sort_scheduler.sv
// tb/tb_red_pitaya_fads_sort_scheduler.sv - self-checking bench for the sort scheduler
module tb_red_pitaya_fads_sort_scheduler;

   localparam logic [31:0] NOW_RST = 32'hFFFF_FFEC;   // 2^32-20

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trig = 1'b0;
   logic        en = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] delay = 32'd100;
   logic [31:0] width = 32'd10;
   logic [31:0] gap = 32'd0;
   logic        sort_pulse, asg_trig;
   logic [3:0]  pending;
   logic [31:0] fired_cnt, late_cnt, dropped_cnt;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   red_pitaya_fads_sort_scheduler #(.TW(32), .QAW(3), .CW(32), .NOW_RST(NOW_RST)) dut (
      .adc_clk_i     (clk),
      .adc_rst_i     (rst),
      .sort_trig_i   (trig),
      .enable_i      (en),
      .flush_i       (flush),
      .sort_delay_i  (delay),
      .pulse_width_i (width),
      .pulse_gap_i   (gap),
      .sort_pulse_o  (sort_pulse),
      .asg_trig_o    (asg_trig),
      .pending_o     (pending),
      .fired_cnt_o   (fired_cnt),
      .late_cnt_o    (late_cnt),
      .dropped_cnt_o (dropped_cnt)
   );

   always #5 clk = ~clk;

   // behavioural model: queue of absolute deadlines plus remaining high/low cycles
   int unsigned m_q[$];
   int unsigned m_now;
   int unsigned m_hi;      // high samples still to come
   int unsigned m_gap;     // edges until a new pulse may start (<=1 means now)
   bit          m_first;
   bit          m_trig_prev;
   longint      m_fired, m_late, m_drop;

   always @(posedge clk) begin
      bit          popped;
      bit          eligible;
      int unsigned d;
      int unsigned due;
      cyc++;
      if (rst) begin
         m_q.delete();
         m_now = NOW_RST; m_hi = 0; m_gap = 0; m_first = 0; m_trig_prev = 0;
         m_fired = 0; m_late = 0; m_drop = 0;
      end else begin
         popped = 0;
         if (flush) begin
            m_q.delete();
            m_hi = 0; m_gap = 0; m_first = 0;
         end else begin
            eligible = (m_hi == 0) && (m_gap <= 1);
            if (m_hi > 0) begin
               m_hi--;
               if (m_hi == 0) m_gap = (gap == 0) ? 1 : gap;
            end else if (m_gap > 0) begin
               m_gap--;
            end
            if (eligible && m_q.size() > 0 && int'(m_now - m_q[0]) >= 0) begin
               due = m_q.pop_front();
               m_hi = (width == 0) ? 1 : width;
               m_first = 1;
               m_fired++;
               if (m_now != due) m_late++;
               popped = 1;
            end else begin
               m_first = 0;
            end
            if (trig && !m_trig_prev && en) begin
               d = (delay == 0) ? 1 : delay;
               if (d > 32'h7FFF_FFFF) d = 32'h7FFF_FFFF;
               if (m_q.size() == 8 && !popped) m_drop++;
               else m_q.push_back(m_now + d);
            end
         end
         m_trig_prev = trig;
         m_now = m_now + 1;
      end
   end

   task automatic check_val(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // continuous comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         check_val("m_pulse",   longint'(sort_pulse), longint'(m_hi > 0));
         check_val("m_asg",     longint'(asg_trig),   longint'(m_first));
         check_val("m_pending", longint'(pending),    longint'(m_q.size()));
         check_val("m_fired",   longint'(fired_cnt),  m_fired);
         check_val("m_late",    longint'(late_cnt),   m_late);
         check_val("m_dropped", longint'(dropped_cnt), m_drop);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // called at a negedge; the event's rising edge lands on edge k
   task automatic fire_event(output int k);
      trig = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   // checks outputs as sampled at clock edge n (must be called with cyc <= n-1)
   task automatic check_at(input int n, input logic ep, input logic ea, input string nm);
      while (cyc < n - 1) @(negedge clk);
      check_val({nm, "_pulse"}, longint'(sort_pulse), longint'(ep));
      check_val({nm, "_asg"},   longint'(asg_trig),   longint'(ea));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, k0;
      repeat (3) @(negedge clk);
      check_val("rst_pulse", longint'(sort_pulse), 0);
      check_val("rst_pending", longint'(pending), 0);
      check_val("rst_fired", longint'(fired_cnt), 0);
      rst = 1'b0;

      // wrapped deadline right after reset: now(k)=2^32-20, due=80
      delay = 100; width = 10; gap = 0;
      fire_event(k);
      check_at(k + 1,   0, 0, "t5_no_early");
      check_at(k + 100, 0, 0, "t5_pre");
      check_at(k + 101, 1, 1, "t5_fire");
      repeat (20) @(negedge clk);

      // basic timing
      do_reset();
      repeat (50) @(negedge clk);
      fire_event(k);
      check_at(k + 100, 0, 0, "t1_before");
      check_at(k + 101, 1, 1, "t1_start");
      check_at(k + 102, 1, 0, "t1_second");
      check_at(k + 110, 1, 0, "t1_last");
      check_at(k + 111, 0, 0, "t1_after");
      check_val("t1_fired", longint'(fired_cnt), 1);
      check_val("t1_late", longint'(late_cnt), 0);

      // zero delay acts as one
      do_reset();
      delay = 0; width = 3;
      fire_event(k);
      check_at(k + 1, 0, 0, "t2_k1");
      check_at(k + 2, 1, 1, "t2_k2");
      repeat (5) @(negedge clk);
      check_val("t2_late", longint'(late_cnt), 0);
      en = 1'b0;
      fire_event(k);
      repeat (3) @(negedge clk);
      check_val("t2_dis_pending", longint'(pending), 0);
      check_val("t2_dis_dropped", longint'(dropped_cnt), 0);
      en = 1'b1;

      // queue overflow
      do_reset();
      delay = 1000; width = 10; gap = 0;
      fire_event(k0);
      for (int i = 1; i < 9; i++) begin
         repeat (4) @(negedge clk);
         fire_event(k);
      end
      check_val("t3_pending_peak", longint'(pending), 8);
      check_val("t3_dropped", longint'(dropped_cnt), 1);
      check_at(k0 + 1001, 1, 1, "t3_first");
      while (cyc < k0 + 1100) @(negedge clk);
      check_val("t3_fired", longint'(fired_cnt), 8);
      check_val("t3_late", longint'(late_cnt), 7);
      check_val("t3_pending_end", longint'(pending), 0);

      // gap between back-to-back pulses
      do_reset();
      delay = 100; width = 50; gap = 20;
      fire_event(k0);
      repeat (9) @(negedge clk);
      fire_event(k);
      check_at(k0 + 101, 1, 1, "t4_first");
      check_at(k0 + 170, 0, 0, "t4_gap_end");
      check_at(k0 + 171, 1, 1, "t4_second");
      while (cyc < k0 + 250) @(negedge clk);
      check_val("t4_fired", longint'(fired_cnt), 2);
      check_val("t4_late", longint'(late_cnt), 1);

      // flush mid-pulse with an event on the flush edge
      do_reset();
      delay = 10; width = 100; gap = 0;
      fire_event(k0);
      for (int i = 1; i < 4; i++) begin
         repeat (2) @(negedge clk);
         fire_event(k);
      end
      while (cyc < k0 + 20) @(negedge clk);
      check_val("t6_pre_pending", longint'(pending), 3);
      check_val("t6_pre_pulse", longint'(sort_pulse), 1);
      flush = 1'b1; trig = 1'b1;
      @(negedge clk);
      flush = 1'b0; trig = 1'b0;
      check_val("t6_flush_pulse", longint'(sort_pulse), 0);
      check_val("t6_flush_pending", longint'(pending), 0);
      repeat (150) @(negedge clk);
      check_val("t6_fired", longint'(fired_cnt), 1);
      check_val("t6_idle_pulse", longint'(sort_pulse), 0);

      // asynchronous reset mid-pulse
      delay = 1; width = 100;
      fire_event(k);
      check_at(k + 20, 1, 0, "t6_mid");
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_val("t6_arst_pulse", longint'(sort_pulse), 0);
      check_val("t6_arst_asg", longint'(asg_trig), 0);
      check_val("t6_arst_pending", longint'(pending), 0);
      check_val("t6_arst_fired", longint'(fired_cnt), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
